iro_sequencer: RTL and testbench

Synchronous controller that runs one measurement on the instrumented ring oscillator and reports the result.
- Latches a run configuration.
- Serially loads the 25-bit seed over the oscillator's bclk/bdat port, with enable low.
- Releases the ring for a programmed number of cycles while counting oscillations.
- Freezes the ring with hold, captures the phase outputs, and reports done.

It sits between the host/register logic and the oscillator instance. It is the only driver of the oscillator's control inputs.

---
 rtl/iro_pkg.sv | 17 +
 rtl/iro_sync.sv | 26 ++
 rtl/iro_sequencer.sv | 149 ++++++++++++++
 tb/tb_iro_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iro_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
// Imported by the sequencer and its testbench.
package iro_pkg;

  localparam int DEF_N_STAGES = 25;
  localparam int LOAD_CYCLES  = 2 * DEF_N_STAGES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HOLD,
    S_CAPTURE,
    S_DONE
  } state_t;

endpackage

// File: rtl/iro_sync.sv
// Multi-flop synchronizer for a bus of asynchronous oscillator phases.
// Each bit is synchronized independently; the bus is not coherent.
module iro_sync #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] ff [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/iro_sequencer.sv
// Runs one measurement on the ring oscillator: seed load, free run,
// hold, phase capture. Sole driver of the oscillator control pins.
module iro_sequencer
  import iro_pkg::*;
#(
  parameter int N_STAGES      = DEF_N_STAGES,
  parameter int RUN_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_STAGES-1:0] cfg_seed,
  input  logic [3:0]          cfg_n_stages,
  input  logic [RUN_W-1:0]    cfg_run_cycles,
  output logic                busy,
  output logic                done,
  output logic [15:0]         phases_q,
  output logic [RUN_W-1:0]    edge_count,
  output logic                iro_rst_n,
  output logic                iro_enable,
  output logic                iro_hold,
  output logic                iro_bclk,
  output logic                iro_bdat,
  output logic [3:0]          iro_n_stages,
  input  logic [15:0]         iro_phases
);

  state_t              state;
  logic [N_STAGES-2:0] seed_sr;
  logic [RUN_W-1:0]    run_len;
  logic [RUN_W-1:0]    cnt;
  logic [15:0]         ph_sync;
  logic                ph0_d;
  logic                rise;

  iro_sync #(
    .W      (16),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (iro_phases),
    .q   (ph_sync)
  );

  assign rise = ph_sync[0] & ~ph0_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      seed_sr      <= '0;
      run_len      <= '0;
      cnt          <= '0;
      ph0_d        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      phases_q     <= '0;
      edge_count   <= '0;
      iro_rst_n    <= 1'b0;
      iro_enable   <= 1'b0;
      iro_hold     <= 1'b0;
      iro_bclk     <= 1'b0;
      iro_bdat     <= 1'b0;
      iro_n_stages <= '0;
    end else begin
      iro_rst_n <= 1'b1;
      ph0_d     <= ph_sync[0];
      done      <= 1'b0;
      if (abort && state != S_IDLE) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        iro_enable <= 1'b0;
        iro_hold   <= 1'b0;
        iro_bclk   <= 1'b0;
        iro_bdat   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              seed_sr      <= cfg_seed[N_STAGES-2:0];
              iro_bdat     <= cfg_seed[N_STAGES-1];
              iro_bclk     <= 1'b0;
              iro_n_stages <= cfg_n_stages;
              run_len      <= (cfg_run_cycles == '0) ?
                              RUN_W'(1) : cfg_run_cycles;
              cnt          <= RUN_W'(N_STAGES - 1);
              edge_count   <= '0;
              busy         <= 1'b1;
              state        <= S_LOAD;
            end
          end
          // bclk low cycle presents a bit, high cycle clocks it in
          S_LOAD: begin
            if (!iro_bclk) begin
              iro_bclk <= 1'b1;
            end else begin
              iro_bclk <= 1'b0;
              if (cnt != '0) begin
                cnt      <= cnt - 1'b1;
                iro_bdat <= seed_sr[N_STAGES-2];
                seed_sr  <= {seed_sr[N_STAGES-3:0], 1'b0};
              end else begin
                iro_bdat   <= 1'b0;
                iro_enable <= 1'b1;
                cnt        <= RUN_W'(1);
                state      <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (rise && edge_count != '1)
              edge_count <= edge_count + 1'b1;
            if (cnt == run_len) begin
              iro_hold <= 1'b1;
              cnt      <= RUN_W'(1);
              state    <= S_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_HOLD: begin
            if (cnt == RUN_W'(SETTLE_CYCLES))
              state <= S_CAPTURE;
            else
              cnt <= cnt + 1'b1;
          end
          S_CAPTURE: begin
            phases_q   <= ph_sync;
            done       <= 1'b1;
            busy       <= 1'b0;
            iro_enable <= 1'b0;
            iro_hold   <= 1'b0;
            state      <= S_DONE;
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iro_sequencer.sv
// Bench for iro_sequencer with a behavioural ring model (period 6 clk)
// and a queue of expected run results.
module tb_iro_sequencer;
  import iro_pkg::*;

  localparam int NS  = DEF_N_STAGES;
  localparam int SET = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] cfg_seed = '0;
  logic [3:0]    cfg_n_stages = '0;
  logic [15:0]   cfg_run_cycles = '0;
  logic          busy, done;
  logic [15:0]   phases_q, edge_count;
  logic          iro_rst_n, iro_enable, iro_hold;
  logic          iro_bclk, iro_bdat;
  logic [3:0]    iro_n_stages;
  logic [15:0]   iro_phases;

  int          ring_ph = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] last_phases = '0;

  typedef struct {
    int done_k;
    int elo;
    int ehi;
  } exp_t;
  exp_t sb[$];

  iro_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_seed       (cfg_seed),
    .cfg_n_stages   (cfg_n_stages),
    .cfg_run_cycles (cfg_run_cycles),
    .busy           (busy),
    .done           (done),
    .phases_q       (phases_q),
    .edge_count     (edge_count),
    .iro_rst_n      (iro_rst_n),
    .iro_enable     (iro_enable),
    .iro_hold       (iro_hold),
    .iro_bclk       (iro_bclk),
    .iro_bdat       (iro_bdat),
    .iro_n_stages   (iro_n_stages),
    .iro_phases     (iro_phases)
  );

  always #5 clk = ~clk;

  // ring advances one step per clk while enabled and not held
  always @(negedge clk)
    if (iro_enable && !iro_hold) ring_ph <= ring_ph + 1;

  function automatic logic [15:0] ring_bits(input int p);
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = ((p + i) % 6) >= 3;
    return b;
  endfunction

  assign iro_phases = ring_bits(ring_ph);

  function automatic exp_t exp_for(input int rc);
    exp_t e;
    int   r;
    r        = (rc == 0) ? 1 : rc;
    e.done_k = 1 + LOAD_CYCLES + r + SET + 1;
    e.elo    = (r / 6 > 0) ? r / 6 - 1 : 0;
    e.ehi    = r / 6 + 1;
    return e;
  endfunction

  // returns at the negedge of cycle t+1 (t = cycle start was sampled)
  task automatic do_start(input logic [NS-1:0] s,
                          input logic [3:0] n,
                          input logic [15:0] r);
    @(negedge clk);
    cfg_seed       = s;
    cfg_n_stages   = n;
    cfg_run_cycles = r;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, iro_enable, iro_hold, iro_bclk,
         iro_bdat, iro_rst_n} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, iro_enable, iro_hold, iro_bclk,
                iro_bdat, iro_rst_n});
    end
    tests++;
    if ({phases_q, edge_count, iro_n_stages} !== 36'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h/%h want 0",
               phases_q, edge_count, iro_n_stages);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (iro_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: got %b want 1", iro_rst_n);
    end
  endtask

  task automatic test_basic();
    logic [NS-1:0] seed = 25'h1A5A5A5;
    logic [NS-1:0] bits = '0;
    int   nrise = 0, first = -1, kd = -1;
    logic en_err = 1'b0, bd_err = 1'b0;
    logic pb = 1'b0, pd = 1'b0;
    exp_t e;
    sb.push_back(exp_for(10));
    do_start(seed, 4'd4, 16'd10);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    tests++;
    if (iro_n_stages !== 4'd4) begin
      fails++;
      $display("FAIL basic_nst: got %0d want 4", iro_n_stages);
    end
    for (int k = 1; k < 200; k++) begin
      if (iro_bclk && !pb) begin
        nrise++;
        bits = {bits[NS-2:0], iro_bdat};
        if (first < 0) first = k;
        if (iro_bdat !== pd) bd_err = 1'b1;
      end
      if (k <= LOAD_CYCLES && iro_enable !== 1'b0) en_err = 1'b1;
      if (done === 1'b1) begin
        kd = k;
        break;
      end
      pb = iro_bclk;
      pd = iro_bdat;
      @(negedge clk);
    end
    e = sb.pop_front();
    tests++;
    if (nrise != NS) begin
      fails++;
      $display("FAIL basic_pulses: got %0d want %0d", nrise, NS);
    end
    tests++;
    if (bits !== seed) begin
      fails++;
      $display("FAIL basic_seed: got %h want %h", bits, seed);
    end
    tests++;
    if (first != 2) begin
      fails++;
      $display("FAIL basic_first_rise: got %0d want 2", first);
    end
    tests++;
    if (en_err !== 1'b0 || bd_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_load_shape: got en=%b bd=%b want 0 0",
               en_err, bd_err);
    end
    tests++;
    if (kd != e.done_k) begin
      fails++;
      $display("FAIL basic_done: got %0d want %0d", kd, e.done_k);
    end
    tests++;
    if (edge_count < e.elo || edge_count > e.ehi) begin
      fails++;
      $display("FAIL basic_edges: got %0d want %0d..%0d",
               edge_count, e.elo, e.ehi);
    end
    tests++;
    if (phases_q !== ring_bits(ring_ph) || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_capture: got %h busy=%b want %h busy=0",
               phases_q, busy, ring_bits(ring_ph));
    end
    last_phases = ring_bits(ring_ph);
  endtask

  task automatic test_ring();
    int   kd = -1;
    exp_t e;
    sb.push_back(exp_for(120));
    do_start(25'h0F0F0F0, 4'd9, 16'd120);
    for (int k = 1; k < 400; k++) begin
      if (done === 1'b1) begin
        kd = k;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    tests++;
    if (kd != e.done_k) begin
      fails++;
      $display("FAIL ring_done: got %0d want %0d", kd, e.done_k);
    end
    tests++;
    if (edge_count < 19 || edge_count > 21) begin
      fails++;
      $display("FAIL ring_edges: got %0d want 19..21", edge_count);
    end
    tests++;
    if (phases_q !== ring_bits(ring_ph)) begin
      fails++;
      $display("FAIL ring_phases: got %h want %h",
               phases_q, ring_bits(ring_ph));
    end
    last_phases = ring_bits(ring_ph);
  endtask

  task automatic test_zero_run();
    int   kd = -1, runc = 0;
    exp_t e;
    sb.push_back(exp_for(0));
    do_start(25'h1555555, 4'd2, 16'd0);
    for (int k = 1; k < 200; k++) begin
      if (iro_enable && !iro_hold) runc++;
      if (done === 1'b1) begin
        kd = k;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    tests++;
    if (runc != 1) begin
      fails++;
      $display("FAIL zero_run_len: got %0d want 1", runc);
    end
    tests++;
    if (kd != e.done_k) begin
      fails++;
      $display("FAIL zero_done: got %0d want %0d", kd, e.done_k);
    end
    last_phases = ring_bits(ring_ph);
  endtask

  task automatic test_abort();
    logic [NS-1:0] seed = 25'h1234567;
    int   ndone = 0, kd = -1;
    exp_t e;
    do_start(seed, 4'd4, 16'd10);
    repeat (24) @(negedge clk);
    tests++;
    if (iro_bclk !== 1'b0 || iro_bdat !== seed[12]) begin
      fails++;
      $display("FAIL abort_bit12: got bclk=%b bdat=%b want 0 %b",
               iro_bclk, iro_bdat, seed[12]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({busy, iro_bclk, iro_enable, done} !== 4'b0) begin
      fails++;
      $display("FAIL abort_outs: got %b want 0000",
               {busy, iro_bclk, iro_enable, done});
    end
    tests++;
    if (phases_q !== last_phases) begin
      fails++;
      $display("FAIL abort_phases: got %h want %h",
               phases_q, last_phases);
    end
    for (int k = 0; k < 80; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d want 0", ndone);
    end
    sb.push_back(exp_for(10));
    do_start(25'h0C3C3C3, 4'd5, 16'd10);
    for (int k = 1; k < 200; k++) begin
      if (done === 1'b1) begin
        kd = k;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    tests++;
    if (kd != e.done_k || phases_q !== ring_bits(ring_ph)) begin
      fails++;
      $display("FAIL abort_rerun: got k=%0d ph=%h want k=%0d ph=%h",
               kd, phases_q, e.done_k, ring_bits(ring_ph));
    end
    last_phases = ring_bits(ring_ph);
  endtask

  task automatic test_start_during_run();
    int   ndone = 0, kd = -1;
    exp_t e;
    sb.push_back(exp_for(10));
    do_start(25'h0AAAAAA, 4'd4, 16'd10);
    repeat (54) @(negedge clk);
    cfg_seed       = 25'h1FFFFFF;
    cfg_n_stages   = 4'd9;
    cfg_run_cycles = 16'd200;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 56; k < 200; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (kd < 0) kd = k;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    tests++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL busy_start_ndone: got %0d want 1", ndone);
    end
    tests++;
    if (kd != e.done_k) begin
      fails++;
      $display("FAIL busy_start_done: got %0d want %0d",
               kd, e.done_k);
    end
    tests++;
    if (iro_n_stages !== 4'd4) begin
      fails++;
      $display("FAIL busy_start_cfg: got %0d want 4", iro_n_stages);
    end
    last_phases = ring_bits(ring_ph);
  endtask

  task automatic test_rst_hold();
    int   kd = -1;
    exp_t e;
    do_start(25'h1FFFFFF, 4'd7, 16'd10);
    repeat (61) @(negedge clk);
    tests++;
    if (iro_hold !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_hold: got hold=%b want 1", iro_hold);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, iro_enable, iro_hold, iro_bclk,
         iro_bdat, iro_rst_n} !== 7'b0 ||
        {phases_q, edge_count, iro_n_stages} !== 36'h0) begin
      fails++;
      $display("FAIL rst_outs: got %b %h/%h/%h want all 0",
               {busy, done, iro_enable, iro_hold, iro_bclk,
                iro_bdat, iro_rst_n},
               phases_q, edge_count, iro_n_stages);
    end
    rst = 1'b0;
    last_phases = '0;
    sb.push_back(exp_for(10));
    do_start(25'h1A5A5A5, 4'd3, 16'd10);
    for (int k = 1; k < 200; k++) begin
      if (done === 1'b1) begin
        kd = k;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    tests++;
    if (kd != e.done_k || phases_q !== ring_bits(ring_ph)) begin
      fails++;
      $display("FAIL rst_rerun: got k=%0d ph=%h want k=%0d ph=%h",
               kd, phases_q, e.done_k, ring_bits(ring_ph));
    end
    tests++;
    if (edge_count < e.elo || edge_count > e.ehi) begin
      fails++;
      $display("FAIL rst_rerun_edges: got %0d want %0d..%0d",
               edge_count, e.elo, e.ehi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ring();
    test_zero_run();
    test_abort();
    test_start_during_run();
    test_rst_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
